// File: rtl/rename_ckpt_rat.sv
// Register alias table with branch checkpoint snapshots for a multi-lane rename stage.
// Optional RAT_WB_BYPASS_EN forwards same-cycle writebacks into the source ready flags.
module rename_ckpt_rat #(
    parameter int PHY_REG_NUM  = 64,
    parameter int DECODE_WIDTH = 2,
    parameter int WB_WIDTH     = 4,
    parameter int CKPT_NUM     = 4,
    localparam int PW = $clog2(PHY_REG_NUM),
    localparam int CW = $clog2(CKPT_NUM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DECODE_WIDTH-1:0]         rename_valid_i,
    input  logic [DECODE_WIDTH-1:0][4:0]    src0_i,
    input  logic [DECODE_WIDTH-1:0][4:0]    src1_i,
    input  logic [DECODE_WIDTH-1:0]         dest_valid_i,
    input  logic [DECODE_WIDTH-1:0][4:0]    dest_i,
    input  logic [DECODE_WIDTH-1:0][PW-1:0] preg_i,
    input  logic [DECODE_WIDTH-1:0]         ckpt_req_i,
    output logic [DECODE_WIDTH-1:0][PW-1:0] psrc0_o,
    output logic [DECODE_WIDTH-1:0][PW-1:0] psrc1_o,
    output logic [DECODE_WIDTH-1:0]         psrc0_ready_o,
    output logic [DECODE_WIDTH-1:0]         psrc1_ready_o,
    output logic [DECODE_WIDTH-1:0][PW-1:0] ppdst_o,
    output logic [DECODE_WIDTH-1:0][CW-1:0] ckpt_id_o,
    output logic                            stall_o,
    input  logic [WB_WIDTH-1:0]             wb_i,
    input  logic [WB_WIDTH-1:0][PW-1:0]     wb_pdest_i,
    input  logic                            ckpt_release_i,
    input  logic                            recover_i,
    input  logic [CW-1:0]                   recover_id_i,
    input  logic                            flush_i,
    input  logic [31:0][PW-1:0]             arch_map_i
);

`ifdef RAT_WB_BYPASS_EN
    localparam bit WB_BYP = 1'b1;
`else
    localparam bit WB_BYP = 1'b0;
`endif

    typedef logic [31:0][PW-1:0] map_t;

    map_t                    map_q;
    map_t                    snap_q [CKPT_NUM];
    logic [PHY_REG_NUM-1:0]  ready_q;
    logic [CW-1:0]           head_q;
    logic [CW-1:0]           tail_q;
    logic [CW:0]             count_q;

    map_t                    map_nxt;
    map_t                    lane_map [DECODE_WIDTH];
    logic [PHY_REG_NUM-1:0]  ready_nxt;
    logic [DECODE_WIDTH-1:0] wr;
    logic [31:0]             busy;
    int                      nreq;
    logic                    accept;
    logic                    rel;
    logic [CW:0]             rcount;

    function automatic logic wb_hit(input logic [PW-1:0] p);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_WIDTH; w++)
            hit = hit | (wb_i[w] && (wb_pdest_i[w] == p));
        return hit && WB_BYP;
    endfunction

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++)
            wr[i] = rename_valid_i[i] && dest_valid_i[i] && (dest_i[i] != 5'd0);
    end

    // Walk lanes in order; map_nxt holds the map as seen by the current lane.
    always_comb begin
        map_nxt       = map_q;
        busy          = '0;
        nreq          = 0;
        psrc0_o       = '0;
        psrc1_o       = '0;
        psrc0_ready_o = '0;
        psrc1_ready_o = '0;
        ppdst_o       = '0;
        ckpt_id_o     = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            lane_map[i] = map_q;
        end
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            psrc0_o[i] = (src0_i[i] == 5'd0) ? '0 : map_nxt[src0_i[i]];
            psrc1_o[i] = (src1_i[i] == 5'd0) ? '0 : map_nxt[src1_i[i]];
            psrc0_ready_o[i] = (src0_i[i] == 5'd0) ||
                (!busy[src0_i[i]] && (ready_q[psrc0_o[i]] || wb_hit(psrc0_o[i])));
            psrc1_ready_o[i] = (src1_i[i] == 5'd0) ||
                (!busy[src1_i[i]] && (ready_q[psrc1_o[i]] || wb_hit(psrc1_o[i])));
            ppdst_o[i]   = (dest_i[i] == 5'd0) ? '0 : map_nxt[dest_i[i]];
            ckpt_id_o[i] = tail_q + CW'(nreq);
            if (wr[i]) begin
                map_nxt[dest_i[i]] = preg_i[i];
                busy[dest_i[i]]    = 1'b1;
            end
            lane_map[i] = map_nxt;
            if (rename_valid_i[i] && ckpt_req_i[i])
                nreq = nreq + 1;
        end
    end

    assign stall_o = (CKPT_NUM - int'(count_q)) < nreq;
    assign accept  = !stall_o && !recover_i && !flush_i;
    assign rcount  = {1'b0, recover_id_i - head_q};
    assign rel     = ckpt_release_i &&
                     (recover_i ? (rcount != '0) : (count_q != '0));

    // Writebacks set first so a same-cycle allocation of that preg wins.
    always_comb begin
        ready_nxt = ready_q;
        for (int w = 0; w < WB_WIDTH; w++)
            if (wb_i[w]) ready_nxt[wb_pdest_i[w]] = 1'b1;
        if (accept)
            for (int i = 0; i < DECODE_WIDTH; i++)
                if (wr[i]) ready_nxt[preg_i[i]] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++)
                map_q[r] <= PW'(r);
            ready_q <= '1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            map_q   <= arch_map_i;
            ready_q <= '1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ready_q <= ready_nxt;
            head_q  <= head_q + CW'(rel);
            if (recover_i) begin
                map_q   <= snap_q[recover_id_i];
                tail_q  <= recover_id_i;
                count_q <= rcount - (CW+1)'(rel);
            end else begin
                if (accept) begin
                    map_q  <= map_nxt;
                    tail_q <= tail_q + CW'(nreq);
                end
                count_q <= count_q + (accept ? (CW+1)'(nreq) : '0)
                           - (CW+1)'(rel);
            end
        end
    end

    // Snapshot contents are don't-care until written, so no reset here.
    always_ff @(posedge clk) begin
        if (accept)
            for (int i = 0; i < DECODE_WIDTH; i++)
                if (rename_valid_i[i] && ckpt_req_i[i])
                    snap_q[ckpt_id_o[i]] <= lane_map[i];
    end

endmodule

// File: tb/tb_rename_ckpt_rat.sv
// Scoreboard bench for rename_ckpt_rat: directed scenarios plus random traffic
// compared against an array-based reference model of the alias table.
module tb_rename_ckpt_rat;
    localparam int DW  = 2;
    localparam int WBW = 4;
    localparam int CN  = 4;
    localparam int PN  = 64;
    localparam int PW  = 6;
    localparam int CW  = 2;

`ifdef RAT_WB_BYPASS_EN
    localparam bit WB_BYP = 1'b1;
`else
    localparam bit WB_BYP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [DW-1:0]         rename_valid_i;
    logic [DW-1:0][4:0]    src0_i, src1_i, dest_i;
    logic [DW-1:0]         dest_valid_i, ckpt_req_i;
    logic [DW-1:0][PW-1:0] preg_i;
    logic [DW-1:0][PW-1:0] psrc0_o, psrc1_o, ppdst_o;
    logic [DW-1:0]         psrc0_ready_o, psrc1_ready_o;
    logic [DW-1:0][CW-1:0] ckpt_id_o;
    logic                  stall_o;
    logic [WBW-1:0]        wb_i;
    logic [WBW-1:0][PW-1:0] wb_pdest_i;
    logic                  ckpt_release_i, recover_i, flush_i;
    logic [CW-1:0]         recover_id_i;
    logic [31:0][PW-1:0]   arch_map_i;

    always #5 clk = ~clk;

    rename_ckpt_rat #(
        .PHY_REG_NUM(PN), .DECODE_WIDTH(DW),
        .WB_WIDTH(WBW), .CKPT_NUM(CN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rename_valid_i(rename_valid_i),
        .src0_i(src0_i), .src1_i(src1_i),
        .dest_valid_i(dest_valid_i), .dest_i(dest_i),
        .preg_i(preg_i), .ckpt_req_i(ckpt_req_i),
        .psrc0_o(psrc0_o), .psrc1_o(psrc1_o),
        .psrc0_ready_o(psrc0_ready_o),
        .psrc1_ready_o(psrc1_ready_o),
        .ppdst_o(ppdst_o), .ckpt_id_o(ckpt_id_o),
        .stall_o(stall_o),
        .wb_i(wb_i), .wb_pdest_i(wb_pdest_i),
        .ckpt_release_i(ckpt_release_i),
        .recover_i(recover_i), .recover_id_i(recover_id_i),
        .flush_i(flush_i), .arch_map_i(arch_map_i)
    );

    typedef struct {
        logic [DW-1:0][PW-1:0] psrc0, psrc1, ppdst;
        logic [DW-1:0]         rdy0, rdy1, pp_chk, id_chk;
        logic [DW-1:0][CW-1:0] cid;
        logic                  stall;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: map, ready bits, snapshots, head and occupancy.
    int m_map [32];
    bit m_rdy [PN];
    int m_snap [CN][32];
    int m_head, m_cnt;

    task automatic chk(input string name, input int lane,
                       input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s lane%0d: got %0d expected %0d",
                      name, lane, act, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_map[r] = r;
        for (int p = 0; p < PN; p++) m_rdy[p] = 1'b1;
        m_head = 0;
        m_cnt  = 0;
    endtask

    function automatic bit writer(input int j);
        return rename_valid_i[j] && dest_valid_i[j] && dest_i[j] != 5'd0;
    endfunction

    function automatic bit wbhit(input int p);
        bit hit;
        hit = 1'b0;
        for (int w = 0; w < WBW; w++)
            if (wb_i[w] && int'(wb_pdest_i[w]) == p) hit = 1'b1;
        return hit && WB_BYP;
    endfunction

    // Youngest earlier writer of s supplies the mapping; else the table does.
    task automatic lookup(input int s, input int lane,
                          output int p, output bit r);
        bit found;
        found = 1'b0;
        p = m_map[s];
        r = m_rdy[p] | wbhit(p);
        for (int j = lane - 1; j >= 0; j--)
            if (!found && writer(j) && int'(dest_i[j]) == s) begin
                found = 1'b1;
                p = preg_i[j];
                r = 1'b0;
            end
        if (s == 0) begin
            p = 0;
            r = 1'b1;
        end
    endtask

    task automatic idle();
        rename_valid_i = '0; src0_i = '0; src1_i = '0;
        dest_valid_i = '0; dest_i = '0; preg_i = '0;
        ckpt_req_i = '0; wb_i = '0; wb_pdest_i = '0;
        ckpt_release_i = 1'b0; recover_i = 1'b0;
        recover_id_i = '0; flush_i = 1'b0;
    endtask

    task automatic issue();
        exp_t e;
        int   nreq, k, nc, slot, p;
        bit   r, stall, acc, rel;
        nreq = 0;
        k = 0;
        for (int i = 0; i < DW; i++)
            if (rename_valid_i[i] && ckpt_req_i[i]) nreq++;
        stall = (CN - m_cnt) < nreq;
        acc = !stall && !recover_i && !flush_i;
        e.stall = stall;
        e.pp_chk = '0; e.id_chk = '0; e.ppdst = '0; e.cid = '0;
        for (int i = 0; i < DW; i++) begin
            lookup(src0_i[i], i, p, r);
            e.psrc0[i] = PW'(p); e.rdy0[i] = r;
            lookup(src1_i[i], i, p, r);
            e.psrc1[i] = PW'(p); e.rdy1[i] = r;
            if (writer(i)) begin
                lookup(dest_i[i], i, p, r);
                e.ppdst[i] = PW'(p); e.pp_chk[i] = 1'b1;
            end
        end
        if (flush_i) begin
            for (int r2 = 0; r2 < 32; r2++) m_map[r2] = arch_map_i[r2];
            for (int p2 = 0; p2 < PN; p2++) m_rdy[p2] = 1'b1;
            m_head = 0;
            m_cnt = 0;
        end else begin
            for (int w = 0; w < WBW; w++)
                if (wb_i[w]) m_rdy[wb_pdest_i[w]] = 1'b1;
            if (recover_i) begin
                nc = (int'(recover_id_i) - m_head + CN) % CN;
                for (int r2 = 0; r2 < 32; r2++)
                    m_map[r2] = m_snap[recover_id_i][r2];
                if (ckpt_release_i && nc > 0) begin
                    m_head = (m_head + 1) % CN;
                    nc--;
                end
                m_cnt = nc;
            end else begin
                rel = ckpt_release_i && m_cnt > 0;
                if (acc) begin
                    for (int i = 0; i < DW; i++) begin
                        if (writer(i)) m_map[dest_i[i]] = preg_i[i];
                        if (rename_valid_i[i] && ckpt_req_i[i]) begin
                            slot = (m_head + m_cnt + k) % CN;
                            for (int r2 = 0; r2 < 32; r2++)
                                m_snap[slot][r2] = m_map[r2];
                            e.cid[i] = CW'(slot);
                            e.id_chk[i] = 1'b1;
                            k++;
                        end
                    end
                    for (int i = 0; i < DW; i++)
                        if (writer(i)) m_rdy[preg_i[i]] = 1'b0;
                    m_cnt += k;
                end
                if (rel) begin
                    m_head = (m_head + 1) % CN;
                    m_cnt--;
                end
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        idle();
        rename_valid_i = DW'($urandom);
        dest_valid_i = DW'($urandom);
        for (int i = 0; i < DW; i++) begin
            src0_i[i] = 5'($urandom_range(0, 7));
            src1_i[i] = 5'($urandom_range(0, 31));
            dest_i[i] = 5'($urandom_range(0, 7));
            preg_i[i] = PW'($urandom_range(1, PN - 1));
            ckpt_req_i[i] = ($urandom_range(0, 2) == 0);
        end
        wb_i = WBW'($urandom);
        for (int w = 0; w < WBW; w++)
            wb_pdest_i[w] = PW'($urandom_range(0, PN - 1));
        ckpt_release_i = ($urandom_range(0, 2) == 0);
        if (m_cnt > 0 && $urandom_range(0, 15) == 0) begin
            recover_i = 1'b1;
            recover_id_i = CW'((m_head + $urandom_range(0, m_cnt - 1)) % CN);
        end
        if ($urandom_range(0, 63) == 0) begin
            flush_i = 1'b1;
            for (int r = 0; r < 32; r++)
                arch_map_i[r] = (r == 0) ? '0 : PW'($urandom_range(0, PN - 1));
        end
        issue();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", 0, stall_o, e.stall);
                for (int i = 0; i < DW; i++) begin
                    chk("psrc0", i, psrc0_o[i], e.psrc0[i]);
                    chk("psrc1", i, psrc1_o[i], e.psrc1[i]);
                    chk("rdy0", i, psrc0_ready_o[i], e.rdy0[i]);
                    chk("rdy1", i, psrc1_ready_o[i], e.rdy1[i]);
                    if (e.pp_chk[i]) chk("ppdst", i, ppdst_o[i], e.ppdst[i]);
                    if (e.id_chk[i]) chk("ckpt_id", i, ckpt_id_o[i], e.cid[i]);
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        idle();
        for (int r = 0; r < 32; r++) arch_map_i[r] = PW'(r);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        idle(); rename_valid_i[0] = 1; src0_i[0] = 5; src1_i[0] = 0; issue();

        idle(); rename_valid_i = 2'b11; dest_valid_i = 2'b11;
        dest_i[0] = 3; preg_i[0] = 40;
        src0_i[1] = 3; dest_i[1] = 3; preg_i[1] = 41; issue();
        idle(); rename_valid_i[0] = 1; src0_i[0] = 3; issue();

        repeat (3) begin
            idle(); rename_valid_i[0] = 1; ckpt_req_i[0] = 1; issue();
        end
        idle(); rename_valid_i = 2'b11; ckpt_req_i = 2'b11;
        dest_valid_i = 2'b01; dest_i[0] = 12; preg_i[0] = 51; issue();
        idle(); rename_valid_i[0] = 1; src0_i[0] = 12; issue();
        idle(); rename_valid_i = 2'b11; ckpt_req_i = 2'b11;
        dest_valid_i = 2'b01; dest_i[0] = 12; preg_i[0] = 52;
        ckpt_release_i = 1; issue();
        idle(); rename_valid_i = 2'b11; ckpt_req_i = 2'b11;
        dest_valid_i = 2'b01; dest_i[0] = 12; preg_i[0] = 50; issue();
        idle(); rename_valid_i[0] = 1; src0_i[0] = 12; issue();

        idle(); flush_i = 1; issue();
        idle(); rename_valid_i[0] = 1; dest_valid_i[0] = 1;
        dest_i[0] = 7; preg_i[0] = 20; ckpt_req_i[0] = 1; issue();
        idle(); rename_valid_i[0] = 1; ckpt_req_i[0] = 1; issue();
        idle(); rename_valid_i[0] = 1; dest_valid_i[0] = 1;
        dest_i[0] = 7; preg_i[0] = 33; issue();
        idle(); rename_valid_i[0] = 1; src0_i[0] = 7; issue();
        idle(); recover_i = 1; recover_id_i = 1; issue();
        idle(); rename_valid_i = 2'b11; src0_i[0] = 7;
        ckpt_req_i = 2'b11; issue();

        idle(); flush_i = 1; issue();
        idle(); rename_valid_i[0] = 1; dest_valid_i[0] = 1;
        dest_i[0] = 9; preg_i[0] = 40; issue();
        idle(); rename_valid_i[0] = 1; src0_i[0] = 9;
        wb_i[0] = 1; wb_pdest_i[0] = 40; issue();
        idle(); rename_valid_i[0] = 1; src0_i[0] = 9; issue();

        idle(); rename_valid_i[0] = 1; dest_valid_i[0] = 1;
        dest_i[0] = 4; preg_i[0] = 44; issue();
        idle(); flush_i = 1; recover_i = 1; recover_id_i = 2;
        for (int r = 0; r < 32; r++)
            arch_map_i[r] = (r == 0) ? '0 : PW'((r * 7 + 3) % PN);
        rename_valid_i[0] = 1; dest_valid_i[0] = 1;
        dest_i[0] = 4; preg_i[0] = 45; ckpt_release_i = 1; issue();
        for (int s = 0; s < 8; s++) begin
            idle(); rename_valid_i = 2'b11;
            src0_i[0] = 5'(s); src1_i[0] = 5'(s + 8);
            src0_i[1] = 5'(s + 16); src1_i[1] = 5'(s + 24);
            ckpt_req_i = 2'b11; issue();
        end

        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                idle();
                rst_n = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            rand_cycle();
        end

        idle();
        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rename_ckpt_rat.md
RENAME_CKPT_RAT -- requirements
Module: rename_ckpt_rat

Interface
REQ-001 SHALL have parameters: PHY_REG_NUM, default 64, physical register count; DECODE_WIDTH, default 2, rename lanes; WB_WIDTH, default 4, writeback ports; CKPT_NUM, default 4, checkpoint slots (power of 2). PW = clog2(PHY_REG_NUM); CW = clog2(CKPT_NUM).
REQ-002 SHALL have these ports, listed as name, direction, width, meaning:
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- rename_valid_i, in, DECODE_WIDTH, lane holds an instruction.
- src0_i and src1_i, in, DECODE_WIDTH x 5, architectural source registers.
- dest_valid_i, in, DECODE_WIDTH, lane writes a destination.
- dest_i, in, DECODE_WIDTH x 5, architectural destination.
- preg_i, in, DECODE_WIDTH x PW, free-list allocation.
- ckpt_req_i, in, DECODE_WIDTH, lane is a branch and needs a snapshot.
- psrc0_o and psrc1_o, out, DECODE_WIDTH x PW, renamed sources.
- psrc0_ready_o and psrc1_ready_o, out, DECODE_WIDTH, source value is available.
- ppdst_o, out, DECODE_WIDTH x PW, previous mapping of dest.
- ckpt_id_o, out, DECODE_WIDTH x CW, slot allocated to each lane.
- stall_o, out, 1, rename group not accepted this cycle.
- wb_i, in, WB_WIDTH, writeback valid.
- wb_pdest_i, in, WB_WIDTH x PW, written-back physical register.
- ckpt_release_i, in, 1, oldest checkpoint retired.
- recover_i, in, 1, branch mispredict.
- recover_id_i, in, CW, slot to restore.
- flush_i, in, 1, exception flush.
- arch_map_i, in, 32 x PW, committed map used on flush.

Function
REQ-003 SHALL hold map[32] (arch to preg), ready[PHY_REG_NUM], CKPT_NUM map snapshots, and a circular checkpoint queue with head, tail and count (CW+1 bits).
REQ-004 SHALL produce psrc, ready and ppdst combinationally in the same cycle from the registered map; map updates SHALL be visible from the next clock edge.
REQ-005 SHALL apply intra-group RAW bypass: if lane j<i has rename_valid, dest_valid and dest_j==src_i (nonzero), psrc_i=preg_j and ready=0; the youngest such j wins.
REQ-006 SHALL apply intra-group WAW bypass: ppdst_i=preg_j of the youngest earlier matching lane; only the youngest writer of a given dest updates the map.
REQ-007 SHALL treat arch reg 0 specially: it always reads preg 0 with ready=1; a dest of 0 SHALL be ignored for map writes and for bypass.
REQ-008 SHALL assert stall_o when CKPT_NUM - count < popcount(ckpt_req_i & rename_valid_i); while stalled, no map, ready or checkpoint state SHALL change from rename.
REQ-009 SHALL clear ready[preg_i] for each accepted map write, and SHALL set ready[wb_pdest_i] for each wb_i; allocation SHALL win on the same preg in the same cycle.
REQ-010 For an accepted lane with ckpt_req_i, SHALL write the map as it stands after lanes 0..i into slot tail+k (k = count of earlier requesting lanes), SHALL output that slot on ckpt_id_o[i], and SHALL advance tail modulo CKPT_NUM.
REQ-011 On ckpt_release_i with count>0, SHALL advance head; with count==0 it SHALL be ignored. Allocation and release in the same cycle SHALL net the count.
REQ-012 On recover_i, SHALL load the map from snapshot recover_id_i, set tail=recover_id_i, recompute count=(recover_id_i-head) mod CKPT_NUM, and ignore rename writes and allocations that cycle. Ready bits SHALL NOT be restored. A concurrent release SHALL still apply.
REQ-013 On flush_i, SHALL set map=arch_map_i, all ready=1, and head=tail=count=0. flush_i SHALL take priority over recover_i, rename and release.

Reset
REQ-014 On reset, map[r] SHALL be r, all ready SHALL be 1, and head, tail and count SHALL be 0. Snapshots SHALL be don't-care. With no inputs active, stall_o SHALL be 0.
REQ-015 Reset asserted mid-operation SHALL immediately discard all checkpoints and pending state.

Configuration
REQ-016 With RAT_WB_BYPASS_EN defined, psrc*_ready_o SHALL also be 1 when the source preg matches any wb_pdest_i with wb_i in the same cycle. Without it, ready SHALL reflect the registered ready bits and intra-group bypass only.

Verification
REQ-017 After reset, rename src0=5 and src1=0 -> psrc0=5, psrc1=0, both ready=1.
REQ-018 Lane0 dest=3 with preg=40; lane1 src0=3 and dest=3 with preg=41 -> lane1 psrc0=40 with ready=0, lane1 ppdst=40, next cycle map[3]=41.
REQ-019 With CKPT_NUM=4 and 3 slots used, 2 ckpt_req lanes -> stall_o=1 and no state change; with ckpt_release_i, stall_o=1 still (count checked pre-release); next cycle accepted.
REQ-020 Snapshot in slot 1 taken with map[7]=20; then rename dest7 to preg 33; recover_id=1 -> map[7]=20, tail=1, count=1 (head=0).
REQ-021 wb_pdest=40 coincident with a read of psrc=40 -> ready=1 only when RAT_WB_BYPASS_EN is defined; ready=1 in both builds on the next cycle.
REQ-022 flush_i together with recover_i -> map equals arch_map_i, count=0, all ready=1.
